// File: rtl/keypad_entry_sequencer.sv
// ============================================================================
//  Module   : keypad_entry_sequencer
//  Purpose  : Turns held keypad strobes into single actions and sequences the
//             BCD entry buffer, target register and run/pause up/down counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int TICK_W   = 26
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [3:0]  key,
  input  logic        ce,
  input  logic        enter,
  input  logic        bs,
  input  logic        ss,
  input  logic        load,
  input  logic        updw,
  input  logic        clr,
  output logic [15:0] buf_val,
  output logic [2:0]  ndig,
  output logic [15:0] cnt_val,
  output logic        dir,
  output logic        running,
  output logic        done,
  output logic [1:0]  mode
);

  typedef enum logic [2:0] {
    ST_ENTRY = 3'd0,
    ST_ARMED = 3'd1,
    ST_PAUSE = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic [15:0]        r_buf, w_buf_n;
  logic [2:0]         r_ndig, w_ndig_n;
  logic [15:0]        r_cnt, w_cnt_n;
  logic [15:0]        r_target, w_target_n;
  logic               r_dir, w_dir_n;
  logic [TICK_W-1:0]  r_pre, w_pre_n;
  logic [6:0]         r_prev;
  logic [6:0]         w_strb;
  logic [6:0]         w_rise;
  logic               w_tick;
  logic [15:0]        w_cnt_step;
  logic               w_step_term;
  logic               w_at_term;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Bit order encodes priority: clr, bs, ce, enter, load, ss, updw.
  assign w_strb = {clr, bs, ce, enter, load, ss, updw};
  assign w_rise = w_strb & ~r_prev;

  assign w_tick      = (r_state == ST_RUN) && (r_pre == TICK_W'(TICK_DIV - 1));
  assign w_cnt_step  = r_dir ? bcd_inc(r_cnt) : bcd_dec(r_cnt);
  assign w_step_term = r_dir ? (w_cnt_step == 16'h9999) : (w_cnt_step == 16'h0000);
  assign w_at_term   = r_dir ? (r_cnt == 16'h9999) : (r_cnt == 16'h0000);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state <= ST_ENTRY;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_buf_n    = r_buf;
    w_ndig_n   = r_ndig;
    w_cnt_n    = r_cnt;
    w_target_n = r_target;
    w_dir_n    = r_dir;
    w_pre_n    = r_pre;
    if (r_state == ST_RUN) begin
      w_pre_n = w_tick ? '0 : r_pre + TICK_W'(1);
    end

    // Any strobe event preempts a coincident tick.
    if (w_rise[6]) begin
      w_state_n  = ST_ENTRY;
      w_buf_n    = '0;
      w_ndig_n   = '0;
      w_cnt_n    = '0;
      w_target_n = '0;
      w_dir_n    = 1'b1;
      w_pre_n    = '0;
    end else if (w_rise[5]) begin
      if ((r_state == ST_ENTRY || r_state == ST_ARMED) && r_ndig != 3'd0) begin
        w_buf_n   = {4'h0, r_buf[15:4]};
        w_ndig_n  = r_ndig - 3'd1;
        w_state_n = ST_ENTRY;
      end
    end else if (w_rise[4]) begin
      if ((r_state == ST_ENTRY || r_state == ST_ARMED) && key <= 4'd9 && r_ndig < 3'd4) begin
        w_buf_n   = {r_buf[11:0], key};
        w_ndig_n  = r_ndig + 3'd1;
        w_state_n = ST_ENTRY;
      end
    end else if (w_rise[3]) begin
      if (r_state == ST_ENTRY && r_ndig != 3'd0) begin
        w_target_n = r_buf;
        w_state_n  = ST_ARMED;
      end
    end else if (w_rise[2]) begin
      if (r_state == ST_ARMED || r_state == ST_PAUSE || r_state == ST_DONE) begin
        w_cnt_n   = r_target;
        w_buf_n   = '0;
        w_ndig_n  = '0;
        w_state_n = ST_PAUSE;
      end
    end else if (w_rise[1]) begin
      case (r_state)
        ST_PAUSE: begin
          w_pre_n   = '0;
          w_state_n = w_at_term ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          w_pre_n   = r_pre;
          w_state_n = ST_PAUSE;
        end
        ST_DONE:  w_state_n = ST_PAUSE;
        default:  w_state_n = r_state;
      endcase
    end else if (w_rise[0]) begin
      w_dir_n = ~r_dir;
    end else if (w_tick) begin
      w_cnt_n = w_cnt_step;
      if (w_step_term) begin
        w_state_n = ST_DONE;
      end
    end
  end

  // Edge-detect flops keep sampling through clr so a held clr acts only once.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_buf    <= '0;
      r_ndig   <= '0;
      r_cnt    <= '0;
      r_target <= '0;
      r_dir    <= 1'b1;
      r_pre    <= '0;
      r_prev   <= '0;
    end else begin
      r_buf    <= w_buf_n;
      r_ndig   <= w_ndig_n;
      r_cnt    <= w_cnt_n;
      r_target <= w_target_n;
      r_dir    <= w_dir_n;
      r_pre    <= w_pre_n;
      r_prev   <= w_strb;
    end
  end

  assign buf_val = r_buf;
  assign ndig    = r_ndig;
  assign cnt_val = r_cnt;
  assign dir     = r_dir;
  assign running = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign mode    = (r_state == ST_ENTRY) ? 2'b00 :
                   (r_state == ST_ARMED) ? 2'b01 : 2'b10;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_sequencer.sv
// ============================================================================
//  Module   : tb_keypad_entry_sequencer
//  Purpose  : Directed vector table plus hand-written corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry_sequencer;

  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 3;

  // Strobe vector order: clr, bs, ce, enter, load, ss, updw
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_CLR   = 7'b1000000;
  localparam logic [6:0] S_BS    = 7'b0100000;
  localparam logic [6:0] S_CE    = 7'b0010000;
  localparam logic [6:0] S_ENTER = 7'b0001000;
  localparam logic [6:0] S_LOAD  = 7'b0000100;
  localparam logic [6:0] S_SS    = 7'b0000010;
  localparam logic [6:0] S_UPDW  = 7'b0000001;

  logic        ck;
  logic        rst;
  logic [3:0]  key;
  logic [6:0]  strb;
  logic        ce, enter, bs, ss, load, updw, clr;
  logic [15:0] buf_val;
  logic [2:0]  ndig;
  logic [15:0] cnt_val;
  logic        dir, running, done;
  logic [1:0]  mode;

  assign {clr, bs, ce, enter, load, ss, updw} = strb;

  keypad_entry_sequencer #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) dut (
    .ck      (ck),
    .rst     (rst),
    .key     (key),
    .ce      (ce),
    .enter   (enter),
    .bs      (bs),
    .ss      (ss),
    .load    (load),
    .updw    (updw),
    .clr     (clr),
    .buf_val (buf_val),
    .ndig    (ndig),
    .cnt_val (cnt_val),
    .dir     (dir),
    .running (running),
    .done    (done),
    .mode    (mode)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct packed {
    logic [6:0]  s;
    logic [3:0]  k;
    logic [15:0] eb;
    logic [2:0]  en;
    logic [15:0] ec;
    logic [1:0]  em;
    logic        ed;
    logic        er;
    logic        edn;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function void add(input logic [6:0] s, input logic [3:0] k, input logic [15:0] eb,
                    input logic [2:0] en, input logic [15:0] ec, input logic [1:0] em,
                    input logic ed, input logic er, input logic edn);
    vec_t v;
    v.s = s; v.k = k; v.eb = eb; v.en = en; v.ec = ec;
    v.em = em; v.ed = ed; v.er = er; v.edn = edn;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] eb, input logic [2:0] en,
                     input logic [15:0] ec, input logic [1:0] em, input logic ed,
                     input logic er, input logic edn);
    n_checks++;
    if ({buf_val, ndig, cnt_val, mode, dir, running, done} !== {eb, en, ec, em, ed, er, edn}) begin
      n_errors++;
      $display("FAIL %s: got buf=%h ndig=%0d cnt=%h mode=%0d dir=%0d run=%0d done=%0d, expected buf=%h ndig=%0d cnt=%h mode=%0d dir=%0d run=%0d done=%0d",
               name, buf_val, ndig, cnt_val, mode, dir, running, done, eb, en, ec, em, ed, er, edn);
    end
  endtask

  task automatic pulse(input logic [6:0] s, input logic [3:0] k);
    strb = s;
    key  = k;
    step();
    strb = S_NONE;
    step();
  endtask

  logic [15:0] down_exp [2:12];

  initial begin
    rst  = 1'b1;
    strb = S_NONE;
    key  = 4'd0;

    // Digit entry, held ce, overflow, backspace, invalid key, enter with empty buffer
    add(S_NONE, 0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_CE,   1, 16'h0001, 1, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0001, 1, 16'h0000, 2'd0, 1, 0, 0);
    add(S_CE,   2, 16'h0012, 2, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0012, 2, 16'h0000, 2'd0, 1, 0, 0);
    add(S_CE,   3, 16'h0123, 3, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0123, 3, 16'h0000, 2'd0, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(S_CE, 4, 16'h1234, 4, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h1234, 4, 16'h0000, 2'd0, 1, 0, 0);
    add(S_CE,   5, 16'h1234, 4, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h1234, 4, 16'h0000, 2'd0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(S_BS | S_CE, 7, 16'h0123, 3, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0123, 3, 16'h0000, 2'd0, 1, 0, 0);
    add(S_BS,   0, 16'h0012, 2, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0012, 2, 16'h0000, 2'd0, 1, 0, 0);
    add(S_BS,   0, 16'h0001, 1, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0001, 1, 16'h0000, 2'd0, 1, 0, 0);
    add(S_BS,   0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_BS,   0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_CE, 4'hA, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_ENTER,0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    // Commit 0012, load, count down
    add(S_CE,   1, 16'h0001, 1, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0001, 1, 16'h0000, 2'd0, 1, 0, 0);
    add(S_CE,   2, 16'h0012, 2, 16'h0000, 2'd0, 1, 0, 0);
    add(S_NONE, 0, 16'h0012, 2, 16'h0000, 2'd0, 1, 0, 0);
    add(S_ENTER,0, 16'h0012, 2, 16'h0000, 2'd1, 1, 0, 0);
    add(S_NONE, 0, 16'h0012, 2, 16'h0000, 2'd1, 1, 0, 0);
    add(S_LOAD, 0, 16'h0000, 0, 16'h0012, 2'd2, 1, 0, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0012, 2'd2, 1, 0, 0);
    add(S_UPDW, 0, 16'h0000, 0, 16'h0012, 2'd2, 0, 0, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0012, 2'd2, 0, 0, 0);
    add(S_SS,   0, 16'h0000, 0, 16'h0012, 2'd2, 0, 1, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0012, 2'd2, 0, 1, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0012, 2'd2, 0, 1, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0012, 2'd2, 0, 1, 0);
    add(S_NONE, 0, 16'h0000, 0, 16'h0011, 2'd2, 0, 1, 0);

    down_exp[2]  = 16'h0010; down_exp[3]  = 16'h0009; down_exp[4]  = 16'h0008;
    down_exp[5]  = 16'h0007; down_exp[6]  = 16'h0006; down_exp[7]  = 16'h0005;
    down_exp[8]  = 16'h0004; down_exp[9]  = 16'h0003; down_exp[10] = 16'h0002;
    down_exp[11] = 16'h0001; down_exp[12] = 16'h0000;

    step();
    step();
    rst = 1'b0;
    chk("reset_state", 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      strb = vecs[i].s;
      key  = vecs[i].k;
      step();
      chk($sformatf("vec%0d", i), vecs[i].eb, vecs[i].en, vecs[i].ec, vecs[i].em,
          vecs[i].ed, vecs[i].er, vecs[i].edn);
    end
    strb = S_NONE;

    // Remaining down-count ticks to terminal 0000
    for (int t = 2; t <= 12; t++) begin
      repeat (4) step();
      chk($sformatf("down_tick%0d", t), 16'h0000, 0, down_exp[t], 2'd2, 0,
          (t < 12) ? 1'b1 : 1'b0, (t == 12) ? 1'b1 : 1'b0);
    end
    repeat (8) step();
    chk("down_done_hold", 16'h0000, 0, 16'h0000, 2'd2, 0, 0, 1);

    // BCD carry 0099 -> 0100
    pulse(S_CLR, 0);
    chk("clr_from_done", 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    pulse(S_CE, 9); pulse(S_CE, 9); pulse(S_ENTER, 0); pulse(S_LOAD, 0);
    chk("load_0099", 16'h0000, 0, 16'h0099, 2'd2, 1, 0, 0);
    pulse(S_SS, 0);
    step(); step();
    chk("up_pre_tick", 16'h0000, 0, 16'h0099, 2'd2, 1, 1, 0);
    step();
    chk("up_carry", 16'h0000, 0, 16'h0100, 2'd2, 1, 1, 0);

    // 9998 -> 9999 then DONE, no wrap
    pulse(S_CLR, 0);
    pulse(S_CE, 9); pulse(S_CE, 9); pulse(S_CE, 9); pulse(S_CE, 8);
    chk("entry_9998", 16'h9998, 4, 16'h0000, 2'd0, 1, 0, 0);
    pulse(S_ENTER, 0); pulse(S_LOAD, 0);
    pulse(S_SS, 0);
    step(); step();
    chk("up_9998_run", 16'h0000, 0, 16'h9998, 2'd2, 1, 1, 0);
    step();
    chk("up_9999_done", 16'h0000, 0, 16'h9999, 2'd2, 1, 0, 1);
    repeat (8) step();
    chk("up_no_wrap", 16'h0000, 0, 16'h9999, 2'd2, 1, 0, 1);
    pulse(S_SS, 0);
    chk("done_to_pause", 16'h0000, 0, 16'h9999, 2'd2, 1, 0, 0);
    pulse(S_SS, 0);
    chk("ss_at_terminal", 16'h0000, 0, 16'h9999, 2'd2, 1, 0, 1);

    // ss on the tick edge, then updw mid-run
    pulse(S_CLR, 0);
    pulse(S_CE, 5); pulse(S_CE, 0); pulse(S_ENTER, 0); pulse(S_LOAD, 0);
    chk("load_0050", 16'h0000, 0, 16'h0050, 2'd2, 1, 0, 0);
    strb = S_SS; step();
    strb = S_NONE; step();
    step(); step();
    strb = S_SS; step();
    chk("ss_beats_tick", 16'h0000, 0, 16'h0050, 2'd2, 1, 0, 0);
    strb = S_NONE; step();
    repeat (6) step();
    chk("pause_holds", 16'h0000, 0, 16'h0050, 2'd2, 1, 0, 0);
    strb = S_SS; step();
    strb = S_NONE; step();
    strb = S_UPDW; step();
    strb = S_NONE; step();
    chk("updw_in_run", 16'h0000, 0, 16'h0050, 2'd2, 0, 1, 0);
    step();
    chk("updw_next_tick", 16'h0000, 0, 16'h0049, 2'd2, 0, 1, 0);

    // clr mid-run
    step();
    strb = S_CLR; step();
    chk("clr_mid_run", 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    strb = S_NONE; step();

    // Asynchronous reset between clock edges
    pulse(S_CE, 7);
    chk("pre_async", 16'h0007, 1, 16'h0000, 2'd0, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 16'h0000, 0, 16'h0000, 2'd0, 1, 0, 0);
    #2;
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
